fir_filter_feedforward: RTL and testbench

- Feedforward 3-tap echo filter: y[n] = x[n] + (x[n-D1]>>S1) + (x[n-D2]>>S2) + (x[n-D3]>>S3).
- It is the feedforward counterpart to the feedback echo path. Delayed terms come from the dry input history, not from the output.
- One shared delay RAM holds the input history. The three taps are read time-multiplexed by a small FSM once per accepted sample.
- Sits in the audio effects chain between the sample source and the mixer. It consumes 16-bit unsigned samples on a valid strobe and produces a 32-bit result with a valid pulse.

---
 rtl/fir_ff_pkg.sv | 21 ++
 rtl/fir_filter_feedforward_ram.sv | 25 ++
 rtl/fir_filter_feedforward.sv | 135 +++++++++++++
 tb/tb_fir_filter_feedforward.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ff_pkg.sv
// Shared types and constants for the feedforward echo filter.
// The delay check rejects tap delays that would alias onto the sample being written.
package fir_ff_pkg;

    localparam int SAMPLE_W = 16;
    localparam int OUT_W    = 32;
    localparam int ACC_W    = 18;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TAP1 = 3'd1,
        TAP2 = 3'd2,
        TAP3 = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic bit delay_ok(input int delay, input int addr_width);
        return (delay >= 1) && (delay <= (1 << addr_width) - 1);
    endfunction

endpackage

// File: rtl/fir_filter_feedforward_ram.sv
// Simple dual-port sample history RAM with registered read, shaped for block RAM inference.
// Contents are deliberately left uninitialised; history validity is tracked by the fill count.
module delay_ram
    import fir_ff_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [SAMPLE_W-1:0]   wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [SAMPLE_W-1:0]   rd_data
);

    logic [SAMPLE_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fir_filter_feedforward.sv
// Feedforward 3-tap echo: y[n] = x[n] + sum of gated, attenuated taps from the dry input history.
// One shared history RAM is read three times per accepted sample by a small FSM.
//
//   state | meaning
//   IDLE  | ready; on accept write x to RAM, snapshot pointer and fill
//   TAP1  | read addr for tap 1 issued; acc = x
//   TAP2  | read addr for tap 2 issued; add tap 1
//   TAP3  | read addr for tap 3 issued; add tap 2
//   DONE  | add tap 3, publish audio_out with out_valid
module fir_filter_feedforward
    import fir_ff_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DELAY1     = 50,
    parameter int DELAY2     = 100,
    parameter int DELAY3     = 150,
    parameter int SHIFT1     = 2,
    parameter int SHIFT2     = 4,
    parameter int SHIFT3     = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] audio_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUT_W-1:0]    audio_out,
    output logic                out_valid,
    output logic                overrun
);

    localparam logic [ADDR_WIDTH-1:0] D1       = ADDR_WIDTH'(DELAY1);
    localparam logic [ADDR_WIDTH-1:0] D2       = ADDR_WIDTH'(DELAY2);
    localparam logic [ADDR_WIDTH-1:0] D3       = ADDR_WIDTH'(DELAY3);
    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;

    generate
        if (!(delay_ok(DELAY1, ADDR_WIDTH) && delay_ok(DELAY2, ADDR_WIDTH) &&
              delay_ok(DELAY3, ADDR_WIDTH))) begin : g_bad_delay
            $error("fir_filter_feedforward: tap delay outside 1..2^ADDR_WIDTH-1");
        end
    endgenerate

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] fill;
    logic [ADDR_WIDTH-1:0] fill_snap;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [SAMPLE_W-1:0]   x;
    logic [SAMPLE_W-1:0]   rd_data;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      term1;
    logic [ACC_W-1:0]      term2;
    logic [ACC_W-1:0]      term3;
    logic                  accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    delay_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_delay_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (audio_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        rd_addr = base - D1;
        case (state)
            TAP2:    rd_addr = base - D2;
            TAP3:    rd_addr = base - D3;
            default: rd_addr = base - D1;
        endcase
    end

    // A tap is only real once at least DELAYk earlier samples have been accepted.
    assign term1 = (fill_snap >= D1) ? ACC_W'(rd_data >> SHIFT1) : '0;
    assign term2 = (fill_snap >= D2) ? ACC_W'(rd_data >> SHIFT2) : '0;
    assign term3 = (fill_snap >= D3) ? ACC_W'(rd_data >> SHIFT3) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            base      <= '0;
            fill      <= '0;
            fill_snap <= '0;
            x         <= '0;
            acc       <= '0;
            audio_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= in_valid && !in_ready;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x         <= audio_in;
                        base      <= wr_ptr;
                        wr_ptr    <= wr_ptr + 1'b1;
                        fill_snap <= fill;
                        if (fill != FILL_MAX) begin
                            fill <= fill + 1'b1;
                        end
                        state <= TAP1;
                    end
                end
                TAP1: begin
                    acc   <= ACC_W'(x);
                    state <= TAP2;
                end
                TAP2: begin
                    acc   <= acc + term1;
                    state <= TAP3;
                end
                TAP3: begin
                    acc   <= acc + term2;
                    state <= DONE;
                end
                DONE: begin
                    audio_out <= OUT_W'(acc + term3);
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_feedforward.sv
// Directed bench for the feedforward echo filter: vector table plus hand-written handshake,
// overrun, mid-operation reset and pointer-wrap sequences.
module tb_fir_filter_feedforward;

    typedef struct {
        bit          rst;
        logic [15:0] din;
        logic [31:0] dout;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] audio_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] audio_out;
    logic        out_valid;
    logic        overrun;

    logic [15:0] w_audio_in;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [31:0] w_audio_out;
    logic        w_out_valid;
    logic        w_overrun;

    int checks = 0;
    int errors = 0;

    vec_t vecs[320];

    fir_filter_feedforward u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .audio_in  (audio_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .audio_out (audio_out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    fir_filter_feedforward #(
        .ADDR_WIDTH (8),
        .DELAY3     (200)
    ) u_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .audio_in  (w_audio_in),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .audio_out (w_audio_out),
        .out_valid (w_out_valid),
        .overrun   (w_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        w_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called on a negedge with the target instance idle; returns on the negedge where out_valid is seen.
    task automatic send(input bit w, input logic [15:0] d, output logic [31:0] q, output bit got);
        int n;
        got = 1'b0;
        q   = '0;
        if (w) begin w_audio_in = d; w_in_valid = 1'b1; end
        else   begin audio_in   = d; in_valid   = 1'b1; end
        @(negedge clk);
        if (w) w_in_valid = 1'b0;
        else   in_valid   = 1'b0;
        n = 0;
        while (!got && n < 12) begin
            if (w ? w_out_valid : out_valid) begin
                got = 1'b1;
                q   = w ? w_audio_out : audio_out;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    initial begin
        logic [31:0] q;
        bit          got;
        int          nz;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        audio_in   = '0;
        w_in_valid = 1'b0;
        w_audio_in = '0;

        for (int i = 0; i < 320; i++) begin
            int k;
            k = i % 160;
            vecs[i].rst = (k == 0);
            if (i < 160) begin
                vecs[i].din  = (k == 0) ? 16'd1024 : 16'd0;
                vecs[i].dout = (k == 0)   ? 32'd1024 :
                               (k == 50)  ? 32'd256  :
                               (k == 100) ? 32'd64   :
                               (k == 150) ? 32'd32   : 32'd0;
            end else begin
                vecs[i].din  = 16'd4096;
                vecs[i].dout = (k < 50)  ? 32'd4096 :
                               (k < 100) ? 32'd5120 :
                               (k < 150) ? 32'd5376 : 32'd5504;
            end
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_audio_out", audio_out, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // Latency and handshake for a single sample
        do_reset();
        audio_in = 16'd1000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                check($sformatf("lat_busy_ready[%0d]", i), {31'b0, in_ready}, 32'd0);
                check($sformatf("lat_busy_valid[%0d]", i), {31'b0, out_valid}, 32'd0);
                @(negedge clk);
            end else begin
                check("lat_out_valid", {31'b0, out_valid}, 32'd1);
                check("lat_ready_back", {31'b0, in_ready}, 32'd1);
                check("lat_audio_out", audio_out, 32'd1000);
            end
        end
        @(negedge clk);
        check("lat_pulse_end", {31'b0, out_valid}, 32'd0);
        check("lat_hold", audio_out, 32'd1000);

        // Impulse and fill-gating tables
        for (int i = 0; i < 320; i++) begin
            if (vecs[i].rst) do_reset();
            send(1'b0, vecs[i].din, q, got);
            if (!got) check($sformatf("tbl_timeout[%0d]", i), 32'd0, 32'd1);
            else      check($sformatf("tbl[%0d]", i), q, vecs[i].dout);
        end

        // Back-to-back: in_valid held high
        do_reset();
        begin
            int acc_cnt, pulses, gap_bad, last;
            acc_cnt = 0; pulses = 0; gap_bad = 0; last = -1;
            audio_in = 16'd0;
            in_valid = 1'b1;
            for (int i = 0; i < 50; i++) begin
                if (in_ready) begin
                    if (last >= 0 && i - last != 5) gap_bad++;
                    last = i;
                    acc_cnt++;
                end
                if (out_valid) pulses++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            check("b2b_accepts", acc_cnt, 32'd10);
            check("b2b_pulses", pulses, 32'd9);
            check("b2b_gap_bad", gap_bad, 32'd0);
        end

        // Overrun: a sample offered two cycles after an accept is dropped
        do_reset();
        audio_in = 16'd2000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        audio_in = 16'd7777;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("ovr_pulse", {31'b0, overrun}, 32'd1);
        @(negedge clk);
        check("ovr_pulse_end", {31'b0, overrun}, 32'd0);
        @(negedge clk);
        check("ovr_out_valid", {31'b0, out_valid}, 32'd1);
        check("ovr_out", audio_out, 32'd2000);
        nz = 0;
        for (int n = 1; n <= 50; n++) begin
            send(1'b0, 16'd0, q, got);
            if (!got) check($sformatf("ovr_timeout[%0d]", n), 32'd0, 32'd1);
            else if (n == 50) check("ovr_tap_hist", q, 32'd500);
            else if (q != 0) nz++;
        end
        check("ovr_quiet", nz, 32'd0);

        // Reset while in TAP2
        audio_in = 16'd3000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_audio_out", audio_out, 32'd0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        nz = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) nz++;
            @(negedge clk);
        end
        check("mid_rst_no_valid", nz, 32'd0);
        nz = 0;
        for (int n = 0; n <= 50; n++) begin
            send(1'b0, (n == 0) ? 16'd1024 : 16'd0, q, got);
            if (!got) check($sformatf("mid_timeout[%0d]", n), 32'd0, 32'd1);
            else if (n == 0)  check("mid_imp0", q, 32'd1024);
            else if (n == 50) check("mid_imp50", q, 32'd256);
            else if (q != 0) nz++;
        end
        check("mid_no_echo", nz, 32'd0);

        // Pointer wrap on the 256-deep instance with a ramp
        do_reset();
        check("wrap_ready", {31'b0, w_in_ready}, 32'd1);
        for (int n = 0; n < 600; n++) begin
            int e;
            e = n;
            if (n >= 50)  e += (n - 50)  >> 2;
            if (n >= 100) e += (n - 100) >> 4;
            if (n >= 200) e += (n - 200) >> 5;
            send(1'b1, 16'(n), q, got);
            if (!got) check($sformatf("wrap_timeout[%0d]", n), 32'd0, 32'd1);
            else      check($sformatf("wrap[%0d]", n), q, 32'(e));
        end
        @(negedge clk);
        check("wrap_no_overrun", {31'b0, w_overrun}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
